rv_exec_ctrl: RTL and testbench

Combinational RV32I decode-and-execute slice for the single-cycle core. It merges three functions: instruction decode/control generation (ctrl_unit function), branch comparison (bru function) and the 32-bit ALU (alu function). Consumers are the PC mux, the register-file write port, the LSU and the write-back mux. The only state is a registered debug pair (instruction-valid and PC).

---
 rtl/rv_pkg.sv | 43 ++++
 rtl/rv_alu.sv | 27 ++
 rtl/rv_bru.sv | 11 +
 rtl/rv_exec_ctrl.sv | 141 ++++++++++++++
 tb/tb_rv_exec_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, ALU op and write-back select encodings for the exec slice
package rv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;
  typedef enum logic [1:0] {
    WB_PC4 = 2'd0,
    WB_ALU = 2'd1,
    WB_LD  = 2'd2
  } wb_sel_e;
  // Maps funct3 plus the funct7[5] alternate bit onto an ALU op for OP/OP-IMM
  function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_alu.sv
// rv_alu: 32-bit RV32I ALU; undefined op codes yield zero
module rv_alu
  import rv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  // Operation select
  always_comb begin
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'd0, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/rv_bru.sv
// rv_bru: branch comparator producing equal and signed/unsigned less flags
module rv_bru (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        uns,
  output logic        less,
  output logic        equal
);
  assign equal = a == b;
  assign less  = uns ? a < b : $signed(a) < $signed(b);
endmodule

// File: rtl/rv_exec_ctrl.sv
// rv_exec_ctrl: single-cycle RV32I decode, branch compare and ALU with registered debug pair
module rv_exec_ctrl
  import rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_pc_br,
  output logic        o_pc_sel,
  output logic        o_rd_wren,
  output logic        o_mem_wren,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_ld_type,
  output logic        o_br_less,
  output logic        o_br_equal,
  output logic        o_insn_vld,
  output logic [31:0] o_pc_debug
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       opa_pc, opb_imm, vld, rd_wren, mem_wren, pc_sel;
  alu_op_e    op;
  wb_sel_e    wb;
  logic [2:0] ld_type;
  logic       unused_bits;
  assign opcode      = i_instr[6:0];
  assign f3          = i_instr[14:12];
  assign f7          = i_instr[31:25];
  assign unused_bits = ^{i_instr[24:15], i_instr[11:7]};
  rv_bru u_bru (
    .a     (i_rs1_data),
    .b     (i_rs2_data),
    .uns   (f3[1]),
    .less  (o_br_less),
    .equal (o_br_equal)
  );
  rv_alu u_alu (
    .op (op),
    .a  (opa_pc ? i_pc : i_rs1_data),
    .b  (opb_imm ? i_imm : i_rs2_data),
    .y  (o_alu_data)
  );
  // Decode; any illegal encoding collapses to a side-effect-free fall-through
  always_comb begin
    opa_pc   = 1'b0;
    opb_imm  = 1'b0;
    op       = ALU_ADD;
    vld      = 1'b1;
    rd_wren  = 1'b0;
    mem_wren = 1'b0;
    pc_sel   = 1'b0;
    wb       = WB_ALU;
    ld_type  = 3'd0;
    case (opcode)
      OP_R: begin
        vld     = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        op      = alu_f3(f3, f7[5]);
        rd_wren = 1'b1;
      end
      OP_I: begin
        opb_imm = 1'b1;
        vld     = !(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
        op      = alu_f3(f3, f3 == 3'd5 && f7[5]);
        rd_wren = 1'b1;
      end
      OP_LOAD: begin
        opb_imm = 1'b1;
        vld     = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rd_wren = 1'b1;
        wb      = WB_LD;
        ld_type = f3;
      end
      OP_STORE: begin
        opb_imm  = 1'b1;
        vld      = f3 < 3'd3;
        mem_wren = 1'b1;
        ld_type  = f3;
      end
      OP_BRANCH: begin
        opa_pc  = 1'b1;
        opb_imm = 1'b1;
        vld     = f3[2:1] != 2'b01;
        pc_sel  = (f3[2] ? o_br_less : o_br_equal) ^ f3[0];
      end
      OP_JAL: begin
        opa_pc  = 1'b1;
        opb_imm = 1'b1;
        pc_sel  = 1'b1;
        rd_wren = 1'b1;
        wb      = WB_PC4;
      end
      OP_JALR: begin
        opb_imm = 1'b1;
        vld     = f3 == 3'd0;
        pc_sel  = 1'b1;
        rd_wren = 1'b1;
        wb      = WB_PC4;
      end
      OP_LUI: begin
        opb_imm = 1'b1;
        op      = ALU_PASSB;
        rd_wren = 1'b1;
      end
      OP_AUIPC: begin
        opa_pc  = 1'b1;
        opb_imm = 1'b1;
        rd_wren = 1'b1;
      end
      default: vld = 1'b0;
    endcase
    if (!vld) begin
      op       = ALU_ADD;
      rd_wren  = 1'b0;
      mem_wren = 1'b0;
      pc_sel   = 1'b0;
      wb       = WB_ALU;
      ld_type  = 3'd0;
    end
  end
  assign o_pc_br    = {o_alu_data[31:1], o_alu_data[0] & (opcode != OP_JALR)};
  assign o_pc_sel   = pc_sel;
  assign o_rd_wren  = rd_wren;
  assign o_mem_wren = mem_wren;
  assign o_wb_sel   = wb;
  assign o_ld_type  = ld_type;
  // Debug capture of the instruction just executed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_insn_vld <= 1'b0;
      o_pc_debug <= '0;
    end else begin
      o_insn_vld <= vld;
      o_pc_debug <= i_pc;
    end
  end
endmodule

// File: tb/tb_rv_exec_ctrl.sv
// tb_rv_exec_ctrl: directed and randomized checks of rv_exec_ctrl against a behavioural model
module tb_rv_exec_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0, imm = '0;
  logic [31:0] alu_data, pc_br, pc_debug;
  logic        pc_sel, rd_wren, mem_wren, br_less, br_equal, insn_vld;
  logic [1:0]  wb_sel;
  logic [2:0]  ld_type;
  int          checks = 0, errs = 0;
  logic        check_en = 1'b0;

  typedef struct packed {
    logic        vld;
    logic [31:0] alu;
    logic [31:0] pc_br;
    logic        pc_sel;
    logic        rd;
    logic        mem;
    logic [1:0]  wb;
    logic [2:0]  ld;
    logic        less;
    logic        eq;
  } exp_t;

  rv_exec_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_instr    (instr),
    .i_pc       (pc),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_imm      (imm),
    .o_alu_data (alu_data),
    .o_pc_br    (pc_br),
    .o_pc_sel   (pc_sel),
    .o_rd_wren  (rd_wren),
    .o_mem_wren (mem_wren),
    .o_wb_sel   (wb_sel),
    .o_ld_type  (ld_type),
    .o_br_less  (br_less),
    .o_br_equal (br_equal),
    .o_insn_vld (insn_vld),
    .o_pc_debug (pc_debug)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = in[6:0];
    f3  = in[14:12];
    f7  = in[31:25];
    e = '0;
    e.wb   = 2'd1;
    e.eq   = a == b;
    e.less = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    case (opc)
      7'h33: begin
        e.vld = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = calc(f3, f7 == 7'h20, a, b);
        e.rd  = 1'b1;
      end
      7'h13: begin
        e.vld = (f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
        e.alu = calc(f3, f3 == 3'd5 && f7 == 7'h20, a, im);
        e.rd  = 1'b1;
      end
      7'h03: begin
        e.vld = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
        e.alu = a + im;
        e.rd  = 1'b1;
        e.wb  = 2'd2;
        e.ld  = f3;
      end
      7'h23: begin
        e.vld = f3 <= 3'd2;
        e.alu = a + im;
        e.mem = 1'b1;
        e.ld  = f3;
      end
      7'h63: begin
        e.vld = f3 != 3'd2 && f3 != 3'd3;
        e.alu = p + im;
        case (f3)
          3'd0:        e.pc_sel = e.eq;
          3'd1:        e.pc_sel = !e.eq;
          3'd4, 3'd6:  e.pc_sel = e.less;
          3'd5, 3'd7:  e.pc_sel = !e.less;
          default:     e.pc_sel = 1'b0;
        endcase
      end
      7'h6F: begin
        e.vld = 1'b1;
        e.alu = p + im;
        e.pc_sel = 1'b1;
        e.rd  = 1'b1;
        e.wb  = 2'd0;
      end
      7'h67: begin
        e.vld = f3 == 3'd0;
        e.alu = a + im;
        e.pc_sel = 1'b1;
        e.rd  = 1'b1;
        e.wb  = 2'd0;
      end
      7'h37: begin
        e.vld = 1'b1;
        e.alu = im;
        e.rd  = 1'b1;
      end
      7'h17: begin
        e.vld = 1'b1;
        e.alu = p + im;
        e.rd  = 1'b1;
      end
      default: e.vld = 1'b0;
    endcase
    e.pc_br = (opc == 7'h67) ? (e.alu & ~32'd1) : e.alu;
    if (!e.vld) begin
      e.pc_sel = 1'b0;
      e.rd     = 1'b0;
      e.mem    = 1'b0;
      e.wb     = 2'd1;
      e.ld     = 3'd0;
    end
    return e;
  endfunction

  exp_t        m;
  logic        e_vld;
  logic [31:0] e_pc;
  always @* m = model(instr, pc, rs1, rs2, imm);

  // Expected debug pair: whatever the model said was valid at the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= 1'b0;
      e_pc  <= '0;
    end else begin
      e_vld <= m.vld;
      e_pc  <= pc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (instr=0x%08h t=%0t)", name, act, exp, instr, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("insn_vld", {31'd0, insn_vld}, {31'd0, e_vld});
      chk("pc_debug", pc_debug, e_pc);
      chk("pc_sel", {31'd0, pc_sel}, {31'd0, m.pc_sel});
      chk("rd_wren", {31'd0, rd_wren}, {31'd0, m.rd});
      chk("mem_wren", {31'd0, mem_wren}, {31'd0, m.mem});
      chk("wb_sel", {30'd0, wb_sel}, {30'd0, m.wb});
      chk("ld_type", {29'd0, ld_type}, {29'd0, m.ld});
      chk("br_less", {31'd0, br_less}, {31'd0, m.less});
      chk("br_equal", {31'd0, br_equal}, {31'd0, m.eq});
      if (m.vld) begin
        chk("alu_data", alu_data, m.alu);
        chk("pc_br", pc_br, m.pc_br);
      end
    end
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(posedge clk);
    #1;
    instr = i;
    pc    = p;
    rs1   = a;
    rs2   = b;
    imm   = im;
    #1;
  endtask

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  initial begin
    #2;
    chk("rst_insn_vld", {31'd0, insn_vld}, 32'd0);
    chk("rst_pc_debug", pc_debug, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    drive({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'h40, 32'd7, 32'hFFFF_FFFF, 32'd0);
    chk("add_alu", alu_data, 32'd6);
    chk("add_rd_wren", {31'd0, rd_wren}, 32'd1);
    chk("add_wb", {30'd0, wb_sel}, 32'd1);
    chk("add_pc_sel", {31'd0, pc_sel}, 32'd0);
    @(posedge clk);
    #1;
    chk("add_insn_vld", {31'd0, insn_vld}, 32'd1);
    chk("add_pc_debug", pc_debug, 32'h40);
    drive({7'h20, 5'd4, 5'd1, 3'd5, 5'd3, 7'h13}, 32'h44, 32'h8000_0000, 32'd0, 32'h404);
    chk("srai_alu", alu_data, 32'hF800_0000);
    drive({7'h00, 5'd4, 5'd1, 3'd5, 5'd3, 7'h13}, 32'h48, 32'h8000_0000, 32'd0, 32'd4);
    chk("srli_alu", alu_data, 32'h0800_0000);
    drive({7'h00, 5'd2, 5'd1, 3'd4, 5'd0, 7'h63}, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    chk("blt_less", {31'd0, br_less}, 32'd1);
    chk("blt_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("blt_pc_br", pc_br, 32'h120);
    drive({7'h00, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63}, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    chk("bltu_pc_sel", {31'd0, pc_sel}, 32'd0);
    drive({12'd0, 5'd1, 3'd0, 5'd1, 7'h67}, 32'h200, 32'h203, 32'd0, 32'd0);
    chk("jalr_pc_br", pc_br, 32'h202);
    chk("jalr_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("jalr_wb", {30'd0, wb_sel}, 32'd0);
    chk("jalr_rd_wren", {31'd0, rd_wren}, 32'd1);
    drive({7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23}, 32'h204, 32'h7000, 32'h55, 32'd4);
    chk("sw_alu", alu_data, 32'h7004);
    chk("sw_mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("sw_rd_wren", {31'd0, rd_wren}, 32'd0);
    chk("sw_ld_type", {29'd0, ld_type}, 32'd2);
    drive(32'h0, 32'h208, 32'h11, 32'h22, 32'h33);
    chk("ill_rd_wren", {31'd0, rd_wren}, 32'd0);
    chk("ill_mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("ill_pc_sel", {31'd0, pc_sel}, 32'd0);
    @(posedge clk);
    #1;
    chk("ill_insn_vld", {31'd0, insn_vld}, 32'd0);
    drive({20'h00010, 5'd1, 7'h6F}, 32'h444, 32'd0, 32'd0, 32'h10);
    @(posedge clk);
    #2;
    chk("pre_rst_pc_debug", pc_debug, 32'h444);
    chk("pre_rst_insn_vld", {31'd0, insn_vld}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_insn_vld", {31'd0, insn_vld}, 32'd0);
    chk("async_rst_pc_debug", pc_debug, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri, ra, rb, rim;
      logic [6:0]  f7;
      int k, s;
      k = $urandom_range(0, 10);
      s = $urandom_range(0, 3);
      ri = $urandom;
      ri[6:0] = (k < 9) ? ops[k] : 7'($urandom);
      f7 = (s < 2) ? 7'h00 : (s == 2) ? 7'h20 : 7'($urandom);
      ri[31:25] = f7;
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h8000_000F;
      rb = ($urandom_range(0, 4) == 0) ? ra : 32'($urandom);
      rim = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($signed(ri[31:20]));
      drive(ri, 32'($urandom) & ~32'd3, ra, rb, rim);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
